pin_verify_lockout: RTL and testbench
=====================================

// Module: pin_verify_lockout
// PURPOSE
//  Parametrised PIN-check state machine for the keypad lock. Compares a
//  strobed BCD user PIN against the stored PIN.
//  Counts consecutive failures and enters a timed LOCKOUT after MAX_TRIES.
//  Supports an ADJUST mode that hands a new PIN to the PIN register via a
//  one-cycle write strobe. Optional idle timeouts relock OPEN and abandon ADJUST.
// PARAMETERS
//  DIGITS        4     BCD digits per PIN; PIN bus width W = 4*DIGITS
//  MAX_TRIES     3     consecutive failures that trigger LOCKOUT (>=1)
//  LOCKOUT_TICKS 2500  clk_500Hz cycles spent in LOCKOUT (5 s) (>=1)
//  ADJ_TICKS     5000  ADJUST idle cycles before abandon to LOCKED (>=1)
//  OPEN_TICKS    0     OPEN cycles before auto-relock; 0 disables
// PORTS
//  clk_500Hz   in   1          system clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  stored_pin  in   W          current PIN from PIN register
//  user_pin    in   W          entered PIN, valid only when valid_pin=1
//  valid_pin   in   1          one-cycle entry strobe
//  adj_sw      in   1          adjust-mode request (level, already synchronised)
//  lock_req    in   1          relock request from OPEN (level or pulse)
//  status      out  2          0=LOCKED 1=OPEN 2=ADJUST 3=LOCKOUT
//  fail_cnt    out  clog2(MAX_TRIES+1)  consecutive failed attempts
//  store_en    out  1          one-cycle write strobe for new_pin
//  new_pin     out  W          PIN to store; meaningful while store_en=1
//  err_pulse   out  1          one-cycle flag: entry rejected
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - status=LOCKED, fail_cnt=0, store_en=0, new_pin=0, err_pulse=0.
//   - All timers=0.
//   - Reset mid-ADJUST never emits store_en.
//  All outputs are registered. Every transition and pulse appears 1 cycle
//  after the sampling edge. store_en and err_pulse are high for exactly 1 cycle.
//  Legal PIN: every nibble <=9. An illegal PIN is never a match.
//  Registered state, updated at each clk_500Hz edge:
//  LOCKED, on valid_pin:
//   - legal && user_pin==stored_pin: go to OPEN, fail_cnt=0.
//   - otherwise: err_pulse=1 and fail_cnt+1. If the new value equals
//     MAX_TRIES, go to LOCKOUT and load the timer with LOCKOUT_TICKS-1.
//  LOCKOUT:
//   - valid_pin is ignored: no err_pulse, no count.
//   - Timer decrements each cycle. At 0, go to LOCKED, fail_cnt=0.
//   - Dwell is exactly LOCKOUT_TICKS cycles.
//  OPEN:
//   - lock_req: go to LOCKED.
//   - else adj_sw=1: go to ADJUST, load the ADJ timer.
//   - lock_req has priority over adj_sw.
//   - valid_pin is ignored.
//   - If OPEN_TICKS>0, the OPEN timer expiry goes to LOCKED.
//  ADJUST:
//   - valid_pin with a legal PIN: store_en=1, new_pin=user_pin, go to LOCKED.
//   - valid_pin with an illegal PIN: err_pulse=1, stay, reload the timer.
//   - adj_sw=0 with no valid_pin that cycle: go to OPEN (abort, nothing stored).
//   - valid_pin and adj_sw falling in the same cycle: the store wins.
//   - Timer expiry after ADJ_TICKS cycles with no entry: go to LOCKED, no store.
//  Width rules:
//   - Timers are clog2(max ticks) wide and never wrap below 0.
//   - fail_cnt saturates at MAX_TRIES.
//  Storing a PIN equal to the old one is legal and still pulses store_en.
// TESTING  (bench: DIGITS=4, MAX_TRIES=3, LOCKOUT_TICKS=8, ADJ_TICKS=6,
//           OPEN_TICKS=0, stored_pin=16'h1234)
//  1 Release rst_n, then valid_pin with 16'h1234 -> status=1 next cycle,
//    fail_cnt=0.
//  2 Three valid_pin with 16'h1111 -> err_pulse x3, fail_cnt=1,2,3.
//    status=3 after the third. valid_pin 16'h1234 during LOCKOUT is ignored.
//    status=0 exactly 8 cycles later, fail_cnt=0.
//  3 Two fails, then 16'h1234 -> OPEN, fail_cnt=0.
//    Then lock_req=1 with adj_sw=1 -> status=0.
//  4 OPEN, adj_sw=1 -> status=2. valid_pin 16'h12A4 -> err_pulse, stay.
//    valid_pin 16'h9876 -> store_en 1 cycle, new_pin=16'h9876, status=0.
//  5 ADJUST, idle 6 cycles -> status=0, no store_en.
//    ADJUST again, drop adj_sw -> status=1.
//  6 Assert rst_n low mid-ADJUST and mid-LOCKOUT -> immediate status=0,
//    fail_cnt=0, store_en never asserted.

Source files
------------

// File: rtl/pin_verify_lockout.sv
// PIN-check state machine for the keypad lock: compares strobed BCD entries,
// counts consecutive failures into a timed lockout, and hands new PINs out in ADJUST.
module pin_verify_lockout #(
    parameter int DIGITS        = 4,
    parameter int MAX_TRIES     = 3,
    parameter int LOCKOUT_TICKS = 2500,
    parameter int ADJ_TICKS     = 5000,
    parameter int OPEN_TICKS    = 0,
    localparam int W            = 4 * DIGITS,
    localparam int FCW          = $clog2(MAX_TRIES + 1)
) (
    input  logic           clk_500Hz,
    input  logic           rst_n,
    input  logic [W-1:0]   stored_pin,
    input  logic [W-1:0]   user_pin,
    input  logic           valid_pin,
    input  logic           adj_sw,
    input  logic           lock_req,
    output logic [1:0]     status,
    output logic [FCW-1:0] fail_cnt,
    output logic           store_en,
    output logic [W-1:0]   new_pin,
    output logic           err_pulse
);

    localparam int LTW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
    localparam int ATW = (ADJ_TICKS > 1) ? $clog2(ADJ_TICKS) : 1;
    localparam int OTW = (OPEN_TICKS > 1) ? $clog2(OPEN_TICKS) : 1;
    localparam int OPEN_LOAD = (OPEN_TICKS > 0) ? OPEN_TICKS - 1 : 0;

    localparam logic [LTW-1:0] LOCK_LD = LTW'(LOCKOUT_TICKS - 1);
    localparam logic [ATW-1:0] ADJ_LD  = ATW'(ADJ_TICKS - 1);
    localparam logic [OTW-1:0] OPEN_LD = OTW'(OPEN_LOAD);
    localparam logic [FCW-1:0] FC_MAX  = FCW'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [FCW-1:0] fail_nxt;
    logic [LTW-1:0] lock_tmr, lock_tmr_nxt;
    logic [ATW-1:0] adj_tmr, adj_tmr_nxt;
    logic [OTW-1:0] open_tmr, open_tmr_nxt;
    logic           store_nxt, err_nxt;
    logic [W-1:0]   new_pin_nxt;
    logic           pin_legal, pin_match;

    // A PIN is legal only if every nibble is a BCD digit.
    always_comb begin
        pin_legal = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (user_pin[4*i +: 4] > 4'd9) pin_legal = 1'b0;
        end
    end

    assign pin_match = pin_legal && (user_pin == stored_pin);

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOCKED;
            fail_cnt  <= '0;
            lock_tmr  <= '0;
            adj_tmr   <= '0;
            open_tmr  <= '0;
            store_en  <= 1'b0;
            new_pin   <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            fail_cnt  <= fail_nxt;
            lock_tmr  <= lock_tmr_nxt;
            adj_tmr   <= adj_tmr_nxt;
            open_tmr  <= open_tmr_nxt;
            store_en  <= store_nxt;
            new_pin   <= new_pin_nxt;
            err_pulse <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fail_nxt     = fail_cnt;
        lock_tmr_nxt = lock_tmr;
        adj_tmr_nxt  = adj_tmr;
        open_tmr_nxt = open_tmr;
        case (state)
            ST_LOCKED: begin
                if (valid_pin) begin
                    if (pin_match) begin
                        state_nxt    = ST_OPEN;
                        fail_nxt     = '0;
                        open_tmr_nxt = OPEN_LD;
                    end else begin
                        if (fail_cnt != FC_MAX) fail_nxt = fail_cnt + 1'b1;
                        if (fail_nxt == FC_MAX) begin
                            state_nxt    = ST_LOCKOUT;
                            lock_tmr_nxt = LOCK_LD;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_tmr == '0) begin
                    state_nxt = ST_LOCKED;
                    fail_nxt  = '0;
                end else begin
                    lock_tmr_nxt = lock_tmr - 1'b1;
                end
            end
            ST_OPEN: begin
                if (lock_req) begin
                    state_nxt = ST_LOCKED;
                end else if (adj_sw) begin
                    state_nxt   = ST_ADJUST;
                    adj_tmr_nxt = ADJ_LD;
                end else if (OPEN_TICKS > 0) begin
                    if (open_tmr == '0) state_nxt = ST_LOCKED;
                    else                open_tmr_nxt = open_tmr - 1'b1;
                end
            end
            ST_ADJUST: begin
                // An entry in the same cycle as adj_sw falling still stores.
                if (valid_pin) begin
                    if (pin_legal) state_nxt   = ST_LOCKED;
                    else           adj_tmr_nxt = ADJ_LD;
                end else if (!adj_sw) begin
                    state_nxt    = ST_OPEN;
                    open_tmr_nxt = OPEN_LD;
                end else if (adj_tmr == '0) begin
                    state_nxt = ST_LOCKED;
                end else begin
                    adj_tmr_nxt = adj_tmr - 1'b1;
                end
            end
            default: state_nxt = ST_LOCKED;
        endcase
    end

    always_comb begin
        store_nxt   = (state == ST_ADJUST) && valid_pin && pin_legal;
        new_pin_nxt = store_nxt ? user_pin : new_pin;
        err_nxt     = valid_pin &&
                      (((state == ST_LOCKED) && !pin_match) ||
                       ((state == ST_ADJUST) && !pin_legal));
    end

    assign status = state;

endmodule

// File: tb/tb_pin_verify_lockout.sv
// Directed bench for pin_verify_lockout with hand-computed expectations.
module tb_pin_verify_lockout;

    logic        clk_500Hz = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] stored_pin = 16'h1234;
    logic [15:0] user_pin   = '0;
    logic        valid_pin  = 1'b0;
    logic        adj_sw     = 1'b0;
    logic        lock_req   = 1'b0;
    logic [1:0]  status;
    logic [1:0]  fail_cnt;
    logic        store_en;
    logic [15:0] new_pin;
    logic        err_pulse;

    int total = 0;
    int bad   = 0;
    int store_cnt = 0;

    pin_verify_lockout #(
        .DIGITS(4), .MAX_TRIES(3), .LOCKOUT_TICKS(8), .ADJ_TICKS(6), .OPEN_TICKS(0)
    ) dut (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .stored_pin(stored_pin),
        .user_pin  (user_pin),
        .valid_pin (valid_pin),
        .adj_sw    (adj_sw),
        .lock_req  (lock_req),
        .status    (status),
        .fail_cnt  (fail_cnt),
        .store_en  (store_en),
        .new_pin   (new_pin),
        .err_pulse (err_pulse)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    always @(negedge clk_500Hz) if (store_en) store_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_500Hz);
            #1;
        end
    endtask

    task automatic pulse_pin(input logic [15:0] pin);
        user_pin  = pin;
        valid_pin = 1'b1;
        step();
        valid_pin = 1'b0;
    endtask

    initial begin
        step(3);
        check("rst_status", status, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_store", store_en, 0);
        check("rst_newpin", new_pin, 0);
        check("rst_err", err_pulse, 0);
        rst_n = 1'b1;
        step();

        // 1: correct PIN opens
        pulse_pin(16'h1234);
        check("t1_status", status, 1);
        check("t1_fail", fail_cnt, 0);
        check("t1_err", err_pulse, 0);
        lock_req = 1'b1; step(); lock_req = 1'b0;
        check("t1_relock", status, 0);

        // 2: three failures into lockout, entry ignored, exact dwell
        pulse_pin(16'h1111);
        check("t2_err1", err_pulse, 1);
        check("t2_fail1", fail_cnt, 1);
        check("t2_stat1", status, 0);
        step();
        check("t2_err_once", err_pulse, 0);
        pulse_pin(16'h1111);
        check("t2_fail2", fail_cnt, 2);
        pulse_pin(16'h1111);
        check("t2_err3", err_pulse, 1);
        check("t2_fail3", fail_cnt, 3);
        check("t2_lockout", status, 3);
        pulse_pin(16'h1234);
        check("t2_ign_err", err_pulse, 0);
        check("t2_ign_stat", status, 3);
        check("t2_ign_fail", fail_cnt, 3);
        step(6);
        check("t2_dwell_last", status, 3);
        step();
        check("t2_release", status, 0);
        check("t2_fail_clr", fail_cnt, 0);

        // 3: two fails then success clears count; lock_req beats adj_sw
        pulse_pin(16'h0000);
        pulse_pin(16'h4321);
        check("t3_fail2", fail_cnt, 2);
        pulse_pin(16'h1234);
        check("t3_open", status, 1);
        check("t3_fail0", fail_cnt, 0);
        lock_req = 1'b1; adj_sw = 1'b1; step(); lock_req = 1'b0; adj_sw = 1'b0;
        check("t3_prio", status, 0);

        // 4: adjust, illegal entry rejected, legal entry stored
        pulse_pin(16'h1234);
        adj_sw = 1'b1; step();
        check("t4_adjust", status, 2);
        pulse_pin(16'h12A4);
        check("t4_bad_err", err_pulse, 1);
        check("t4_bad_stay", status, 2);
        check("t4_bad_nostore", store_en, 0);
        pulse_pin(16'h9876);
        check("t4_store", store_en, 1);
        check("t4_newpin", new_pin, 16'h9876);
        check("t4_locked", status, 0);
        check("t4_noerr", err_pulse, 0);
        adj_sw = 1'b0; step();
        check("t4_store_once", store_en, 0);
        check("t4_store_cnt", store_cnt, 1);

        // 5: adjust timeout, then adjust abort
        pulse_pin(16'h1234);
        adj_sw = 1'b1; step();
        check("t5_adjust", status, 2);
        step(5);
        check("t5_still_adj", status, 2);
        step();
        check("t5_timeout", status, 0);
        check("t5_nostore", store_cnt, 1);
        pulse_pin(16'h1234);
        check("t5_open", status, 1);
        step();
        check("t5_adj2", status, 2);
        adj_sw = 1'b0; step();
        check("t5_abort", status, 1);
        check("t5_abort_nostore", store_cnt, 1);

        // store wins over adj_sw falling; same PIN still stores
        adj_sw = 1'b1; step();
        check("t5b_adj", status, 2);
        adj_sw = 1'b0;
        pulse_pin(16'h1234);
        check("t5b_store", store_en, 1);
        check("t5b_newpin", new_pin, 16'h1234);
        check("t5b_locked", status, 0);

        // 6: reset mid-ADJUST and mid-LOCKOUT
        pulse_pin(16'h1234);
        adj_sw = 1'b1; step();
        check("t6_adj", status, 2);
        user_pin = 16'h5555; valid_pin = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_adj_stat", status, 0);
        check("t6_rst_adj_store", store_en, 0);
        step(2);
        valid_pin = 1'b0; adj_sw = 1'b0; rst_n = 1'b1;
        check("t6_no_store", store_cnt, 2);
        pulse_pin(16'h0001);
        pulse_pin(16'h0002);
        pulse_pin(16'h0003);
        check("t6_lockout", status, 3);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_lo_stat", status, 0);
        check("t6_rst_lo_fail", fail_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_pin(16'h1234);
        check("t6_after_open", status, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
